wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 122 ++++++++++++
 tb/tb_wb_arbiter2.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone pipelined arbiter: round-robin on ties, registered grant,
// zero-latency request passthrough from the owning master to the shared bus.
module wb_arbiter2 #(
    parameter int AW               = 5,
    parameter int DW               = 32,
    parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_data,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    output logic [DW-1:0]     o_a_data,
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [DW-1:0]     i_b_data,
    input  logic [DW/8-1:0]   i_b_sel,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic [DW-1:0]     o_b_data,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } grant_e;

    grant_e grant_q;
    logic   last_b_q;
    logic   own_a, own_b, idle, pass_b;

    // Ownership is released only by the owner dropping cyc or a bus error;
    // there is never a direct hand-over, so every switch passes through IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            grant_q  <= IDLE;
            last_b_q <= 1'b1;
        end else begin
            case (grant_q)
                IDLE: begin
                    if (i_a_cyc && (!i_b_cyc || last_b_q)) begin
                        grant_q  <= OWN_A;
                        last_b_q <= 1'b0;
                    end else if (i_b_cyc) begin
                        grant_q  <= OWN_B;
                        last_b_q <= 1'b1;
                    end
                end
                OWN_A:   if (!i_a_cyc || i_wb_err) grant_q <= IDLE;
                OWN_B:   if (!i_b_cyc || i_wb_err) grant_q <= IDLE;
                default: grant_q <= IDLE;
            endcase
        end
    end

    assign own_a  = (grant_q == OWN_A);
    assign own_b  = (grant_q == OWN_B);
    assign idle   = !own_a && !own_b;
    assign pass_b = own_b || (idle && last_b_q);

    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_wb_we  = 1'b0;
        if (own_a) begin
            o_wb_cyc = i_a_cyc;
            o_wb_stb = i_a_stb;
            o_wb_we  = i_a_we;
        end else if (own_b) begin
            o_wb_cyc = i_b_cyc;
            o_wb_stb = i_b_stb;
            o_wb_we  = i_b_we;
        end
    end

    // Without zeroing, the idle bus keeps showing the most recent owner's request.
    always_comb begin
        if (idle && OPT_ZERO_ON_IDLE) begin
            o_wb_addr = '0;
            o_wb_data = '0;
            o_wb_sel  = '0;
        end else if (pass_b) begin
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
        end else begin
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
        end
    end

    assign o_a_stall = own_a ? i_wb_stall : 1'b1;
    assign o_a_ack   = own_a && i_wb_ack && i_a_cyc;
    assign o_a_err   = own_a && i_wb_err && i_a_cyc;
    assign o_b_stall = own_b ? i_wb_stall : 1'b1;
    assign o_b_ack   = own_b && i_wb_ack && i_b_cyc;
    assign o_b_err   = own_b && i_wb_err && i_b_cyc;
    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus randomized traffic, all checked
// every cycle against an ownership-level reference model.
module tb_wb_arbiter2;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [SW-1:0] a_sel, b_sel;
    logic          o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic [DW-1:0] o_a_data, o_b_data;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [SW-1:0] o_wb_sel;
    logic          wb_stall, wb_ack, wb_err;
    logic [DW-1:0] wb_data;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model: owner 0 = nobody, 1 = A, 2 = B; last = most recently granted master
    int m_own  = 0;
    int m_last = 2;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(AW), .DW(DW), .OPT_ZERO_ON_IDLE(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we),
        .i_a_addr(a_addr), .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we),
        .i_b_addr(b_addr), .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_data)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int next_owner(int own, int last, bit a, bit b, bit err);
        if (own == 0) begin
            if (a && b) return (last == 1) ? 2 : 1;
            if (a) return 1;
            if (b) return 2;
            return 0;
        end
        if (own == 1) return (!a || err) ? 0 : 1;
        return (!b || err) ? 0 : 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_own  <= 0;
            m_last <= 2;
        end else begin
            m_own <= next_owner(m_own, m_last, a_cyc, b_cyc, wb_err);
            if (m_own == 0 && next_owner(m_own, m_last, a_cyc, b_cyc, wb_err) != 0)
                m_last <= next_owner(m_own, m_last, a_cyc, b_cyc, wb_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ea, eb;
            ea = (m_own == 1);
            eb = (m_own == 2);
            check("wb_cyc", 64'(o_wb_cyc), 64'(ea ? a_cyc : (eb ? b_cyc : 1'b0)));
            check("wb_stb", 64'(o_wb_stb), 64'(ea ? a_stb : (eb ? b_stb : 1'b0)));
            check("wb_we", 64'(o_wb_we), 64'(ea ? a_we : (eb ? b_we : 1'b0)));
            check("wb_addr", 64'(o_wb_addr), 64'(ea ? a_addr : (eb ? b_addr : '0)));
            check("wb_data", 64'(o_wb_data), 64'(ea ? a_data : (eb ? b_data : '0)));
            check("wb_sel", 64'(o_wb_sel), 64'(ea ? a_sel : (eb ? b_sel : '0)));
            check("a_stall", 64'(o_a_stall), 64'(ea ? wb_stall : 1'b1));
            check("a_ack", 64'(o_a_ack), 64'(ea & wb_ack & a_cyc));
            check("a_err", 64'(o_a_err), 64'(ea & wb_err & a_cyc));
            check("b_stall", 64'(o_b_stall), 64'(eb ? wb_stall : 1'b1));
            check("b_ack", 64'(o_b_ack), 64'(eb & wb_ack & b_cyc));
            check("b_err", 64'(o_b_err), 64'(eb & wb_err & b_cyc));
            check("a_data", 64'(o_a_data), 64'(wb_data));
            check("b_data", 64'(o_b_data), 64'(wb_data));
        end
    end

    task automatic clear_inputs();
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0; a_sel = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0; b_sel = '0;
        wb_stall = 0; wb_ack = 0; wb_err = 0; wb_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int winner, issued, acks_a, acks_b, stall_cyc;
        bit acc, did_stall;
        rst = 1'b1;
        clear_inputs();
        do_reset();
        chk_en = 1'b1;

        // reset state, with idle masters presenting non-zero request fields
        a_addr = 5'h1f; a_data = 32'hdeadbeef; a_sel = 4'hf; a_we = 1'b1;
        @(negedge clk);
        check("rst_wb_cyc", 64'(o_wb_cyc), 64'd0);
        check("rst_wb_addr", 64'(o_wb_addr), 64'd0);
        check("rst_wb_we", 64'(o_wb_we), 64'd0);
        check("rst_a_stall", 64'(o_a_stall), 64'd1);
        check("rst_b_stall", 64'(o_b_stall), 64'd1);
        check("rst_a_ack", 64'(o_a_ack), 64'd0);

        // single write from A to word 3
        next_cycle();
        a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 5'd3; a_data = 32'h12345678; a_sel = 4'hf;
        @(negedge clk);
        check("wr_latency_cyc", 64'(o_wb_cyc), 64'd0);
        next_cycle();
        @(negedge clk);
        check("wr_cyc", 64'(o_wb_cyc), 64'd1);
        check("wr_stb", 64'(o_wb_stb), 64'd1);
        check("wr_addr", 64'(o_wb_addr), 64'd3);
        check("wr_data", 64'(o_wb_data), 64'h12345678);
        check("wr_b_stall", 64'(o_b_stall), 64'd1);
        next_cycle();
        a_stb = 0; wb_ack = 1;
        @(negedge clk);
        check("wr_a_ack", 64'(o_a_ack), 64'd1);
        check("wr_b_ack", 64'(o_b_ack), 64'd0);
        next_cycle();
        a_cyc = 0; wb_ack = 0;
        next_cycle();

        // first tie after reset goes to A, then B after one idle cycle
        do_reset();
        a_cyc = 1; a_addr = 5'd1; b_cyc = 1; b_addr = 5'd2;
        next_cycle();
        @(negedge clk);
        check("tie0_a_stall", 64'(o_a_stall), 64'd0);
        check("tie0_b_stall", 64'(o_b_stall), 64'd1);
        next_cycle();
        a_cyc = 0;
        @(negedge clk);
        check("drop_same_cycle", 64'(o_wb_cyc), 64'd0);
        next_cycle();
        @(negedge clk);
        check("gap_idle_cyc", 64'(o_wb_cyc), 64'd0);
        check("gap_b_stall", 64'(o_b_stall), 64'd1);
        next_cycle();
        @(negedge clk);
        check("b_after_gap_stall", 64'(o_b_stall), 64'd0);
        check("b_after_gap_addr", 64'(o_wb_addr), 64'd2);
        next_cycle();
        b_cyc = 0;
        next_cycle();

        // four further ties alternate A, B, A, B
        for (int k = 0; k < 4; k++) begin
            a_cyc = 1; b_cyc = 1;
            next_cycle();
            @(negedge clk);
            winner = !o_a_stall ? 1 : (!o_b_stall ? 2 : 0);
            check("tie_winner", 64'(winner), (k % 2 == 0) ? 64'd1 : 64'd2);
            next_cycle();
            a_cyc = 0; b_cyc = 0;
            next_cycle();
        end

        // B: four pipelined reads, slave stalls the second strobe once
        issued = 0; acks_a = 0; acks_b = 0; stall_cyc = 0; did_stall = 0;
        b_cyc = 1; b_stb = 1; b_we = 0; b_addr = 5'd7;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acks_a += int'(o_a_ack);
            acks_b += int'(o_b_ack);
            if (wb_stall) begin
                stall_cyc++;
                check("rd_b_stall", 64'(o_b_stall), 64'd1);
            end
            acc = b_stb && !o_b_stall;
            next_cycle();
            wb_ack = acc;
            wb_data = 32'hb0000000 + 32'(issued);
            if (acc) issued++;
            b_stb = (issued < 4);
            b_addr = 5'd7 + 5'(issued);
            wb_stall = (issued == 1) && !did_stall;
            if (wb_stall) did_stall = 1;
        end
        check("rd_issued", 64'(issued), 64'd4);
        check("rd_b_acks", 64'(acks_b), 64'd4);
        check("rd_a_acks", 64'(acks_a), 64'd0);
        check("rd_stall_cycles", 64'(stall_cyc), 64'd1);
        b_cyc = 0; b_stb = 0; wb_ack = 0; wb_stall = 0;
        next_cycle();

        // A: three writes, error on the second
        a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 5'd9;
        next_cycle();
        @(negedge clk);
        check("err_w1_stb", 64'(o_wb_stb), 64'd1);
        next_cycle();
        wb_ack = 1; a_addr = 5'd10;
        @(negedge clk);
        check("err_w1_ack", 64'(o_a_ack), 64'd1);
        next_cycle();
        wb_ack = 0; wb_err = 1; a_addr = 5'd11;
        @(negedge clk);
        check("err_a_err", 64'(o_a_err), 64'd1);
        check("err_b_err", 64'(o_b_err), 64'd0);
        next_cycle();
        wb_err = 0; wb_ack = 1; a_stb = 0;
        @(negedge clk);
        check("err_then_idle_cyc", 64'(o_wb_cyc), 64'd0);
        check("err_late_ack", 64'(o_a_ack), 64'd0);
        check("err_then_stall", 64'(o_a_stall), 64'd1);
        next_cycle();
        wb_ack = 0; a_cyc = 0;
        next_cycle();
        next_cycle();

        // reset while B has a read outstanding
        b_cyc = 1; b_stb = 1; b_we = 0; b_addr = 5'd4;
        next_cycle();
        @(negedge clk);
        check("rr_granted", 64'(o_wb_cyc), 64'd1);
        next_cycle();
        b_stb = 0; rst = 1;
        next_cycle();
        rst = 0; wb_ack = 1;
        @(negedge clk);
        check("rr_cyc_dropped", 64'(o_wb_cyc), 64'd0);
        check("rr_b_ack", 64'(o_b_ack), 64'd0);
        check("rr_a_ack", 64'(o_a_ack), 64'd0);
        next_cycle();
        wb_ack = 0; b_cyc = 0;
        next_cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if ($urandom_range(7) == 0) a_cyc = ~a_cyc;
            if ($urandom_range(7) == 0) b_cyc = ~b_cyc;
            a_stb = a_cyc ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
            b_stb = b_cyc ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
            a_we = 1'($urandom_range(1));
            b_we = 1'($urandom_range(1));
            a_addr = AW'($urandom);
            b_addr = AW'($urandom);
            a_data = $urandom;
            b_data = $urandom;
            a_sel = SW'($urandom);
            b_sel = SW'($urandom);
            wb_stall = ($urandom_range(3) == 0);
            wb_ack = ($urandom_range(2) == 0);
            wb_err = ($urandom_range(15) == 0);
            wb_data = $urandom;
            rst = ($urandom_range(99) == 0);
        end
        next_cycle();
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
